// File: rtl/servo_hall_decoder.sv
// servo_hall_decoder: hall sensor front end. Synchronises the raw hall code,
// optionally glitch-filters it, decodes the commutation sector, and tracks
// direction, signed step position and the period between commutation edges.
// Optional feature: define HALL_FILTER_EN to include the glitch filter.
module servo_hall_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned POS_W      = 32,
    parameter int unsigned PERIOD_W   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              hall,
    input  logic                    pos_clr,
    input  logic                    fault_clr,
    output logic [2:0]              sector,
    output logic                    direction,
    output logic                    edge_pulse,
    output logic signed [POS_W-1:0] position,
    output logic [PERIOD_W-1:0]     period,
    output logic                    period_valid,
    output logic                    stall,
    output logic                    fault
);
    localparam int unsigned         CNT_W      = 8;
    localparam logic [2:0]          NO_SECTOR  = 3'd7;
    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    state_t              state;
    logic [2:0]          sync1;
    logic [2:0]          sync2;
    logic [2:0]          filt;
    logic [2:0]          filt_sector;
    logic                changed;
    logic                step_fwd;
    logic                step_rev;
    logic                step;
    logic                bad;
    logic                have_prev;
    logic [PERIOD_W-1:0] cnt;

    // Forward sequence 001,011,010,110,100,101 maps to sectors 0..5.
    function automatic logic [2:0] code_to_sector(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd0;
            3'b011:  return 3'd1;
            3'b010:  return 3'd2;
            3'b110:  return 3'd3;
            3'b100:  return 3'd4;
            3'b101:  return 3'd5;
            default: return NO_SECTOR;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous hall inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
        end
    end

`ifdef HALL_FILTER_EN
    logic [2:0]       cand;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] stable_nxt;

    // Consecutive-sample count of the current candidate; restarts on any change.
    always_comb begin
        stable_nxt = CNT_W'(1);
        if (sync2 == cand) begin
            stable_nxt = (stable_cnt == '1) ? stable_cnt : stable_cnt + CNT_W'(1);
        end
    end

    // Accept a new code once it has been stable for FILTER_LEN samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand       <= '0;
            stable_cnt <= '0;
            filt       <= '0;
        end else begin
            cand       <= sync2;
            stable_cnt <= stable_nxt;
            if ((sync2 != filt) && (stable_nxt >= CNT_W'(FILTER_LEN))) begin
                filt <= sync2;
            end
        end
    end
`else
    // Filter length has no meaning once the filter is removed.
    localparam int unsigned filter_len_unused = FILTER_LEN;

    // Synchronised code feeds the decoder directly.
    always_comb filt = sync2;
`endif

    // Classify a filtered-code change against the held sector.
    always_comb begin
        filt_sector = code_to_sector(filt);
        changed     = (state == TRACK) && (filt_sector != sector);
        step_fwd    = changed && (filt_sector == ((sector == 3'd5) ? 3'd0 : sector + 3'd1));
        step_rev    = changed && (filt_sector == ((sector == 3'd0) ? 3'd5 : sector - 3'd1));
        bad         = changed && !step_fwd && !step_rev;
        step        = step_fwd || step_rev;
    end

    // Decoder FSM: sector, direction, position, edge pulse and sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            sector     <= NO_SECTOR;
            direction  <= 1'b1;
            edge_pulse <= 1'b0;
            position   <= '0;
            fault      <= 1'b0;
            have_prev  <= 1'b0;
        end else begin
            edge_pulse <= 1'b0;
            case (state)
                INIT: begin
                    if (filt_sector != NO_SECTOR) begin
                        sector <= filt_sector;
                        state  <= TRACK;
                    end
                end
                TRACK: begin
                    if (step_fwd) begin
                        sector     <= filt_sector;
                        direction  <= 1'b1;
                        position   <= position + POS_W'(1);
                        edge_pulse <= 1'b1;
                        have_prev  <= 1'b1;
                    end else if (step_rev) begin
                        sector     <= filt_sector;
                        direction  <= 1'b0;
                        position   <= position - POS_W'(1);
                        edge_pulse <= 1'b1;
                        have_prev  <= 1'b1;
                    end else if (bad) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault     <= 1'b0;
                        sector    <= NO_SECTOR;
                        have_prev <= 1'b0;
                        state     <= INIT;
                    end
                end
                default: state <= INIT;
            endcase
            if (pos_clr) begin
                position <= '0;
            end
        end
    end

    // Edge-to-edge period meter; a saturated count is never reported as valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
        end else if (step) begin
            cnt   <= PERIOD_W'(1);
            stall <= 1'b0;
            if (have_prev && (step_fwd == direction) && (cnt != PERIOD_MAX)) begin
                period       <= cnt;
                period_valid <= 1'b1;
            end else begin
                period_valid <= 1'b0;
            end
        end else begin
            if (cnt != PERIOD_MAX) begin
                cnt <= cnt + PERIOD_W'(1);
            end
            if (cnt >= PERIOD_MAX - PERIOD_W'(1)) begin
                stall        <= 1'b1;
                period_valid <= 1'b0;
            end
            if ((state == FAULT) && fault_clr) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_hall_decoder.sv
// Bench for servo_hall_decoder: directed scenarios plus randomized hall
// segments, checked against a segment-level behavioural model.
module tb_servo_hall_decoder;
    localparam int unsigned FL    = 4;
    localparam int unsigned POSW  = 16;
    localparam int unsigned PW    = 8;
    localparam int          SAT   = (1 << PW) - 1;
`ifdef HALL_FILTER_EN
    localparam int          LAT    = FL + 3;
    localparam int          MINLEN = FL;
`else
    localparam int          LAT    = 3;
    localparam int          MINLEN = 1;
`endif
    localparam int S_INIT = 0, S_TRACK = 1, S_FAULT = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [2:0]             hall;
    logic                   pos_clr;
    logic                   fault_clr;
    logic [2:0]             sector;
    logic                   direction;
    logic                   edge_pulse;
    logic signed [POSW-1:0] position;
    logic [PW-1:0]          period;
    logic                   period_valid;
    logic                   stall;
    logic                   fault;

    servo_hall_decoder #(.FILTER_LEN(FL), .POS_W(POSW), .PERIOD_W(PW)) dut (
        .clk(clk), .rst(rst), .hall(hall), .pos_clr(pos_clr), .fault_clr(fault_clr),
        .sector(sector), .direction(direction), .edge_pulse(edge_pulse),
        .position(position), .period(period), .period_valid(period_valid),
        .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_edge_obs = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (edge_pulse === 1'b1) n_edge_obs <= n_edge_obs + 1;

    // Behavioural model state, advanced per accepted hall code.
    int                     seq_code[6] = '{1, 3, 2, 6, 4, 5};
    int                     m_state, m_sector, m_period, m_edges, m_busy, m_org;
    bit                     m_dir, m_pv, m_fault, m_have_prev;
    logic signed [POSW-1:0] m_pos;
    logic [2:0]             m_filt, cur_hall;

    function automatic int sec_of(input logic [2:0] code);
        for (int i = 0; i < 6; i++) if (int'(code) == seq_code[i]) return i;
        return 7;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Model reaction to a filtered code taking effect at cycle t.
    task automatic m_accept(input logic [2:0] code, input int t);
        int s, d;
        bit fwd;
        s = sec_of(code);
        m_filt = code;
        if (m_busy < t) m_busy = t;
        if (m_state == S_INIT) begin
            if (s < 6) begin
                m_sector = s;
                m_state  = S_TRACK;
            end
        end else if (m_state == S_TRACK) begin
            d = (s + 6 - m_sector) % 6;
            if (s >= 6 || (d != 1 && d != 5)) begin
                m_state = S_FAULT;
                m_fault = 1'b1;
            end else begin
                fwd = (d == 1);
                m_edges++;
                if (m_have_prev && fwd == m_dir && (t - m_org) < SAT) begin
                    m_period = t - m_org;
                    m_pv     = 1'b1;
                end else begin
                    m_pv = 1'b0;
                end
                m_dir       = fwd;
                m_have_prev = 1'b1;
                m_org       = t;
                m_pos       = fwd ? m_pos + 16'sd1 : m_pos - 16'sd1;
                m_sector    = s;
            end
        end
    endtask

    task automatic check_all();
        bit stall_e;
        if (cyc >= m_busy + 1) begin
            stall_e = (cyc >= m_org + SAT - 1);
            chk("sector", int'(sector), m_sector);
            chk("direction", int'(direction), int'(m_dir));
            chk("position", int'(position), int'(m_pos));
            chk("period", int'(period), m_period);
            chk("period_valid", int'(period_valid), int'(m_pv && !stall_e));
            chk("stall", int'(stall), int'(stall_e));
            chk("fault", int'(fault), int'(m_fault));
            chk("edge_count", n_edge_obs, m_edges);
        end
    endtask

    // Drive one hall segment of n cycles, optionally with pos_clr on the step
    // cycle (pc) or a fault_clr pulse in the first cycle (fc).
    task automatic seg(input logic [2:0] code, input int n, input bit pc, input bit fc);
        int c0;
        check_all();
        c0 = cyc;
        if (fc && m_state == S_FAULT) begin
            m_state = S_INIT; m_sector = 7; m_fault = 1'b0; m_pv = 1'b0; m_have_prev = 1'b0;
            if (sec_of(m_filt) < 6) begin
                m_sector = sec_of(m_filt);
                m_state  = S_TRACK;
            end
            if (m_busy < c0 + 2) m_busy = c0 + 2;
        end
        hall = code;
        if (n >= MINLEN && code != m_filt) m_accept(code, c0 + LAT);
        if (pc) m_pos = '0;
        cur_hall = code;
        for (int k = 0; k < n; k++) begin
            pos_clr   = pc && (k == LAT - 1);
            fault_clr = fc && (k == 0);
            @(negedge clk);
        end
        pos_clr   = 1'b0;
        fault_clr = 1'b0;
    endtask

    initial begin
        int                     c0, r, s, e0;
        logic [2:0]             code;
        logic signed [POSW-1:0] p0;

        rst = 1'b1; hall = 3'b000; pos_clr = 1'b0; fault_clr = 1'b0;
        m_state = S_INIT; m_sector = 7; m_period = 0; m_edges = 0; m_busy = 0;
        m_dir = 1'b1; m_pv = 1'b0; m_fault = 1'b0; m_have_prev = 1'b0;
        m_pos = '0; m_filt = 3'b000; cur_hall = 3'b000;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_sector", int'(sector), 7);
        chk("rst_direction", int'(direction), 1);
        chk("rst_edge", int'(edge_pulse), 0);
        chk("rst_position", int'(position), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_fault", int'(fault), 0);
        rst   = 1'b0;
        m_org = cyc + 1;
        repeat (2) @(negedge clk);

        // First legal code: exact acceptance latency, no edge.
        c0 = cyc;
        hall = 3'b001; cur_hall = 3'b001;
        m_accept(3'b001, c0 + LAT);
        repeat (LAT - 1) @(negedge clk);
        chk("lat_before", int'(sector), 7);
        @(negedge clk);
        chk("lat_at", int'(sector), 0);
        chk("lat_pos", int'(position), 0);
        chk("lat_noedge", n_edge_obs, 0);
        repeat (20) @(negedge clk);

        // Forward rotation, 100 cycles per code.
        for (int i = 1; i <= 6; i++) seg(3'(seq_code[i % 6]), 100, 1'b0, 1'b0);
        check_all();
        chk("fwd_pos", int'(position), 6);
        chk("fwd_dir", int'(direction), 1);
        chk("fwd_period", int'(period), 100);
        chk("fwd_pv", int'(period_valid), 1);

        // Clear position, then reverse two steps.
        pos_clr = 1'b1; @(negedge clk); pos_clr = 1'b0; m_pos = '0;
        seg(3'b101, 100, 1'b0, 1'b0);
        seg(3'b100, 100, 1'b0, 1'b0);
        chk("rev_pv_after_reversal_edge_next", int'(period_valid), 1);
        check_all();
        chk("rev_pos", int'(position), -2);
        chk("rev_dir", int'(direction), 0);
        chk("rev_period", int'(period), 100);

        // Back to sector 0, then a 3-cycle glitch to 011.
        seg(3'b101, 60, 1'b0, 1'b0);
        seg(3'b001, 60, 1'b0, 1'b0);
        e0 = m_edges; p0 = m_pos;
        seg(3'b011, 3, 1'b0, 1'b0);
        seg(3'b001, 60, 1'b0, 1'b0);
        check_all();
        chk("glitch_sector", int'(sector), 0);
        chk("glitch_pos", int'(position), int'(p0));
`ifdef HALL_FILTER_EN
        chk("glitch_edges", n_edge_obs, e0);
`else
        chk("glitch_edges", n_edge_obs, e0 + 2);
`endif

        // Illegal jump, ignored codes while faulted, then recovery into INIT.
        seg(3'b110, 60, 1'b0, 1'b0);
        chk("fault_set", int'(fault), 1);
        seg(3'b010, 60, 1'b0, 1'b0);
        chk("fault_hold_sector", int'(sector), 0);
        seg(3'b111, 40, 1'b0, 1'b0);
        e0 = m_edges;
        seg(3'b010, 60, 1'b0, 1'b1);
        check_all();
        chk("clr_sector", int'(sector), 2);
        chk("clr_fault", int'(fault), 0);
        chk("clr_noedge", n_edge_obs, e0);

        // Hold long enough to saturate, then step with pos_clr in the same cycle.
        repeat (SAT + 5) @(negedge clk);
        check_all();
        chk("stall_set", int'(stall), 1);
        chk("stall_pv", int'(period_valid), 0);
        seg(3'b110, 60, 1'b1, 1'b0);
        check_all();
        chk("stall_clear", int'(stall), 0);
        chk("stall_pos", int'(position), 0);
        chk("stall_sector", int'(sector), 3);

        // Randomized segments: neighbours, glitches, illegal codes, fault clears.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) begin
                do code = 3'($urandom_range(0, 7)); while (code == cur_hall);
                seg(code, $urandom_range(1, (FL > 1) ? FL - 1 : 1), 1'b0, 1'b0);
            end else if (r < 16) begin
                do code = 3'($urandom_range(0, 7)); while (code == cur_hall);
                seg(code, $urandom_range(LAT + 1, 150), 1'b0, 1'b0);
            end else begin
                s = sec_of(m_filt);
                if (s > 5) s = $urandom_range(0, 5);
                code = 3'(seq_code[($urandom_range(0, 1) != 0) ? (s + 1) % 6 : (s + 5) % 6]);
                if (code == cur_hall) code = 3'(seq_code[(sec_of(code) == (s + 1) % 6) ? (s + 5) % 6 : (s + 1) % 6]);
                seg(code, $urandom_range(LAT + 1, 150), 1'b0,
                    (m_state == S_FAULT) && (cyc >= m_busy + 1) && ($urandom_range(0, 1) != 0));
            end
        end
        repeat (LAT + 2) @(negedge clk);
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/servo_hall_decoder.md
# servo_hall_decoder

Hall-sensor front end for the servo controller: the feedback-side counterpart of the 3-phase commutation actuator. Samples the raw 3-bit hall code (a, b, c), synchronises and glitch-filters it, decodes the commutation sector, tracks rotation direction and a signed commutation-step position, and measures the clock-cycle period between consecutive commutation edges. Illegal codes and illegal sector jumps raise a sticky fault. Outputs feed the speed/position loops and select the actuator's commutation direction.

## Interface
- FILTER_LEN, 4: consecutive stable synchronised samples required before a hall change is accepted; legal range 1..255
- POS_W, 32: width of signed position counter
- PERIOD_W, 24: width of edge-period counter
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- hall  in  3  raw hall code {a, b, c}, asynchronous to clk
- pos_clr  in  1  synchronous clear of position to 0
- fault_clr  in  1  clears sticky fault; decoder re-enters INIT
- sector  out  3  current sector 0..5; 7 when no valid sector is held
- direction  out  1  1 = forward (last accepted step +1), 0 = reverse
- edge  out  1  one-cycle pulse per accepted commutation step
- position  out  POS_W  signed step count, two's complement, wraps
- period  out  PERIOD_W  cycles between last two same-direction edges
- period_valid  out  1  period holds a valid measurement
- stall  out  1  period counter saturated since last edge
- fault  out  1  sticky illegal-code / illegal-jump flag

## Operation
- Synchroniser: 2 flops on hall. Filter: candidate register plus stability counter; filtered code updates when the synchronised value has differed from the filtered value and held the same candidate for FILTER_LEN consecutive cycles. Any candidate change restarts the count.
- Forward sequence (sector 0..5): 001, 011, 010, 110, 100, 101, wrapping to 001. 000 and 111 are illegal.
- FSM states INIT, TRACK, FAULT. Reset state INIT.
- INIT: sector = 7. First legal filtered code loads sector, goes to TRACK; no edge, position unchanged, period_valid = 0.
- TRACK, new filtered code:
  - Step +1 mod 6: edge = 1, position += 1, direction = 1.
  - Step -1 mod 6: edge = 1, position -= 1, direction = 0.
  - Illegal code or step of ±2/±3: fault = 1, go to FAULT; sector, position and direction hold; no edge.
- FAULT: all hall changes ignored. fault_clr → fault = 0, sector = 7, period_valid = 0, go to INIT.
- Period counter: increments every cycle, saturating at 2^PERIOD_W-1; reset to 1 in the cycle following an edge. On an edge in the same direction as the previous edge (both in TRACK), period <= counter and period_valid = 1. First edge after INIT, or an edge that reverses direction, sets period_valid = 0 and does not update period.
- stall = 1 and period_valid = 0 while the counter is saturated; stall clears on the next edge.
- pos_clr wins over a same-cycle step: position = 0.
- fault_clr has no effect outside FAULT.
- Reset values: sector = 7, direction = 1, edge = 0, position = 0, period = 0, period_valid = 0, stall = 0, fault = 0. Filter state and counters are cleared.

## Timing
- Hall change stable from cycle t: sector, edge, position and direction update at t + FILTER_LEN + 3. Edge is high for exactly 1 cycle.
- Period equals the cycle distance between two edge pulses; for steady input toggling every N cycles (N > FILTER_LEN+3), period = N.
- Glitches shorter than FILTER_LEN cycles after synchronisation are never accepted.
- Reset mid-operation clears everything at once; the first legal code afterwards is treated as in INIT.

## Configuration
- HALL_FILTER_EN defined: the glitch filter is present as described.
- HALL_FILTER_EN undefined: the filter is removed and the synchronised code feeds the decoder directly. Latency becomes t + 3; FILTER_LEN is ignored.

## Test plan
- Reset, then hall = 001 held: after FILTER_LEN+3 = 7 cycles, sector = 0 and state is TRACK; no edge; position = 0.
- Forward rotation 001→011→010→110→100→101→001, each code held 100 cycles: 6 edges, position = 6, direction = 1, period = 100, period_valid = 1 from the second edge.
- Reverse rotation from sector 0 (001→101→100), 100 cycles each: position = -2, direction = 0; the reversal edge clears period_valid; the next edge gives period = 100.
- 3-cycle pulse 011 inside steady 001 (FILTER_LEN = 4): no edge and sector stays 0. Without HALL_FILTER_EN the same pulse produces edges: +1 then -1.
- Illegal jump 001→110 or code 111: fault = 1, and later legal codes cause no change. fault_clr then 010: INIT, sector = 2, fault = 0.
- Hold one code for 2^PERIOD_W cycles (PERIOD_W = 8): stall = 1 and period_valid = 0. The next forward step clears stall; pos_clr in that same cycle leaves position = 0.
